// File: rtl/gol_sequencer.sv
// gol_sequencer: run controller for an external 8x8 Game of Life grid.
// It loads a seed into the grid, lets the grid run for a target number of
// generations (or until the grid stops changing), captures the final grid
// and pulses o_done. While idle it keeps the grid frozen on the last result.
// Optional feature: define GOL_SEQUENCER_POPCOUNT_EN to add o_pop, a
// registered live-cell count of o_result.
module gol_sequencer #(
  parameter int GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [63:0]      i_seed,
  input  logic [GEN_W-1:0] i_gens,
  output logic             o_gol_reset,
  output logic [63:0]      o_gol_vals,
  input  logic [63:0]      i_gol_vals,
  output logic             o_busy,
  output logic             o_done,
  output logic [63:0]      o_result,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_stable
`ifdef GOL_SEQUENCER_POPCOUNT_EN
  ,
  output logic [6:0]       o_pop
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [63:0]      seed_q;
  logic [63:0]      prev_q;
  logic [GEN_W-1:0] target_q;
  logic [GEN_W-1:0] gen_cnt;
  logic             is_final;
  logic             is_static;

  // The terminal compare is evaluated before any increment, so gen_cnt
  // never has to count past the target and cannot wrap.
  assign is_final  = (gen_cnt == target_q);
  assign is_static = (gen_cnt != '0) && (i_gol_vals == prev_q);

  // The grid only reads o_gol_vals while o_gol_reset is high: the seed in
  // LOAD, otherwise the last captured result so the grid stays frozen on it.
  assign o_gol_vals = (state == S_LOAD) ? seed_q : o_result;

  // Sequencer FSM with registered handshake outputs and result capture.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      seed_q      <= '0;
      prev_q      <= '0;
      target_q    <= '0;
      gen_cnt     <= '0;
      o_result    <= '0;
      o_gen_count <= '0;
      o_stable    <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_gol_reset <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            seed_q      <= i_seed;
            target_q    <= i_gens;
            o_stable    <= 1'b0;
            o_busy      <= 1'b1;
            o_gol_reset <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            o_busy      <= 1'b0;
            o_gol_reset <= 1'b1;
            state       <= S_IDLE;
          end else begin
            gen_cnt     <= '0;
            o_gol_reset <= 1'b0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            o_busy      <= 1'b0;
            o_gol_reset <= 1'b1;
            state       <= S_IDLE;
          end else if (is_final || is_static) begin
            o_result    <= i_gol_vals;
            o_gen_count <= gen_cnt;
            o_stable    <= !is_final;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            o_gol_reset <= 1'b1;
            state       <= S_DONE;
          end else begin
            prev_q  <= i_gol_vals;
            gen_cnt <= gen_cnt + GEN_W'(1);
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_done      <= 1'b0;
          o_busy      <= 1'b0;
          o_gol_reset <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GOL_SEQUENCER_POPCOUNT_EN
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  // Live-cell count taken from the same grid word that lands in o_result,
  // so it is valid alongside o_done.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_pop <= '0;
    end else if ((state == S_RUN) && !i_abort && (is_final || is_static)) begin
      o_pop <= popcount64(i_gol_vals);
    end
  end
`endif

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed bench for gol_sequencer with a behavioural toroidal 8x8 Life grid.
module tb_gol_sequencer;

  localparam int GEN_W = 16;

  localparam logic [63:0] BLINK_H = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 11);
  localparam logic [63:0] BLINK_V = (64'd1 << 2) | (64'd1 << 10) | (64'd1 << 18);
  localparam logic [63:0] BLOCK   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

  logic             i_clk;
  logic             i_reset;
  logic             i_start;
  logic             i_abort;
  logic [63:0]      i_seed;
  logic [GEN_W-1:0] i_gens;
  logic             o_gol_reset;
  logic [63:0]      o_gol_vals;
  logic [63:0]      i_gol_vals;
  logic             o_busy;
  logic             o_done;
  logic [63:0]      o_result;
  logic [GEN_W-1:0] o_gen_count;
  logic             o_stable;
`ifdef GOL_SEQUENCER_POPCOUNT_EN
  logic [6:0]       o_pop;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gol_sequencer #(.GEN_W(GEN_W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_seed      (i_seed),
    .i_gens      (i_gens),
    .o_gol_reset (o_gol_reset),
    .o_gol_vals  (o_gol_vals),
    .i_gol_vals  (i_gol_vals),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_gen_count (o_gen_count),
    .o_stable    (o_stable)
`ifdef GOL_SEQUENCER_POPCOUNT_EN
    ,
    .o_pop       (o_pop)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference Life rule on an 8x8 torus, bit index x+8*y.
  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] nxt;
    int n;
    nxt = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
              n += int'(g[((x + dx + 8) % 8) + 8 * ((y + dy + 8) % 8)]);
            end
          end
        end
        nxt[x + 8 * y] = (n == 3) || (g[x + 8 * y] && n == 2);
      end
    end
    return nxt;
  endfunction

  // Grid model: loads while o_gol_reset is high, otherwise steps once per clock.
  always @(posedge i_clk) begin
    if (o_gol_reset) i_gol_vals <= o_gol_vals;
    else             i_gol_vals <= life_step(i_gol_vals);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run in cycle t and wait (bounded) for o_done; lat = cycles after t.
  task automatic run_wait(input logic [63:0] seed, input logic [GEN_W-1:0] gens,
                          input int limit, output int lat);
    i_seed  = seed;
    i_gens  = gens;
    i_start = 1'b1;
    lat = 0;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      lat++;
    end while (!o_done && lat < limit);
  endtask

  initial begin
    int lat;
    bit seen;
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_seed     = '0;
    i_gens     = '0;
    i_gol_vals = '0;
    repeat (3) @(negedge i_clk);

    // reset state
    chk("rst_busy",   64'(o_busy),      64'd0);
    chk("rst_done",   64'(o_done),      64'd0);
    chk("rst_result", o_result,         64'd0);
    chk("rst_gcnt",   64'(o_gen_count), 64'd0);
    chk("rst_stable", 64'(o_stable),    64'd0);
    chk("rst_golrst", 64'(o_gol_reset), 64'd1);
    chk("rst_golval", o_gol_vals,       64'd0);
    i_reset = 1'b1;
    @(negedge i_clk);

    // horizontal blinker, 3 generations
    run_wait(BLINK_H, 16'd3, 50, lat);
    chk("blink_lat",    64'(lat),         64'd6);
    chk("blink_result", o_result,         BLINK_V);
    chk("blink_gcnt",   64'(o_gen_count), 64'd3);
    chk("blink_stable", 64'(o_stable),    64'd0);
    chk("blink_busy",   64'(o_busy),      64'd0);
    chk("blink_golrst", 64'(o_gol_reset), 64'd1);
    @(negedge i_clk);
    chk("blink_done1", 64'(o_done), 64'd0);
    chk("idle_golval", o_gol_vals,  BLINK_V);

    // 2x2 block stops as static after one generation
    run_wait(BLOCK, 16'd100, 200, lat);
    chk("block_lat",    64'(lat),         64'd4);
    chk("block_result", o_result,         BLOCK);
    chk("block_gcnt",   64'(o_gen_count), 64'd1);
    chk("block_stable", 64'(o_stable),    64'd1);
`ifdef GOL_SEQUENCER_POPCOUNT_EN
    chk("block_pop",    64'(o_pop),       64'd4);
`endif
    @(negedge i_clk);

    // glider returns to its start after 32 generations on the torus
    run_wait(GLIDER, 16'd32, 100, lat);
    chk("glider_lat",    64'(lat),         64'd35);
    chk("glider_result", o_result,         GLIDER);
    chk("glider_gcnt",   64'(o_gen_count), 64'd32);
    chk("glider_stable", 64'(o_stable),    64'd0);
    @(negedge i_clk);

    // zero generations returns the seed
    run_wait(64'hA5, 16'd0, 20, lat);
    chk("zero_lat",    64'(lat),         64'd3);
    chk("zero_result", o_result,         64'hA5);
    chk("zero_gcnt",   64'(o_gen_count), 64'd0);
    chk("zero_stable", 64'(o_stable),    64'd0);
    @(negedge i_clk);

    // empty grid is static at gen_cnt=1
    run_wait(64'd0, 16'd10, 50, lat);
    chk("empty_lat",    64'(lat),         64'd4);
    chk("empty_gcnt",   64'(o_gen_count), 64'd1);
    chk("empty_stable", 64'(o_stable),    64'd1);
    @(negedge i_clk);

    // abort takes priority over start in IDLE
    i_seed = BLINK_H; i_gens = 16'd3; i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("abst_busy", 64'(o_busy), 64'd0);

    // restore a known result, then abort a blinker run at t+4
    run_wait(BLINK_H, 16'd3, 50, lat);
    @(negedge i_clk);
    i_seed = BLINK_H; i_gens = 16'd3; i_start = 1'b1;
    @(negedge i_clk);  // t+1 LOAD
    i_start = 1'b0;
    chk("load_busy",   64'(o_busy),      64'd1);
    chk("load_golrst", 64'(o_gol_reset), 64'd1);
    chk("load_golval", o_gol_vals,       BLINK_H);
    @(negedge i_clk);  // t+2 RUN
    chk("run_golrst",  64'(o_gol_reset), 64'd0);
    @(negedge i_clk);  // t+3
    @(negedge i_clk);  // t+4
    i_abort = 1'b1;
    @(negedge i_clk);  // t+5
    i_abort = 1'b0;
    chk("abort_busy",   64'(o_busy),      64'd0);
    chk("abort_golrst", 64'(o_gol_reset), 64'd1);
    seen = o_done;
    repeat (6) begin
      @(negedge i_clk);
      seen |= o_done;
    end
    chk("abort_nodone", 64'(seen),        64'd0);
    chk("abort_result", o_result,         BLINK_V);
    chk("abort_gcnt",   64'(o_gen_count), 64'd3);

    // abort beats a same-cycle completion (gens=2 captures in t+4)
    i_seed = GLIDER; i_gens = 16'd2; i_start = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    seen = o_done;
    repeat (4) begin
      @(negedge i_clk);
      seen |= o_done;
    end
    chk("abcmp_nodone", 64'(seen),        64'd0);
    chk("abcmp_result", o_result,         BLINK_V);
    chk("abcmp_gcnt",   64'(o_gen_count), 64'd3);

    // reset mid-run at t+4
    i_seed = BLINK_H; i_gens = 16'd3; i_start = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("mrst_busy",   64'(o_busy),      64'd0);
    chk("mrst_done",   64'(o_done),      64'd0);
    chk("mrst_result", o_result,         64'd0);
    chk("mrst_gcnt",   64'(o_gen_count), 64'd0);
    chk("mrst_golrst", 64'(o_gol_reset), 64'd1);
    chk("mrst_golval", o_gol_vals,       64'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    run_wait(BLINK_H, 16'd3, 50, lat);
    chk("post_lat",    64'(lat),         64'd6);
    chk("post_result", o_result,         BLINK_V);
    chk("post_gcnt",   64'(o_gen_count), 64'd3);
    @(negedge i_clk);

    // maximum target completes without wrapping
    run_wait(BLINK_H, 16'hFFFF, 70000, lat);
    chk("max_lat",    64'(lat),         64'd65538);
    chk("max_result", o_result,         BLINK_V);
    chk("max_gcnt",   64'(o_gen_count), 64'hFFFF);
    chk("max_stable", 64'(o_stable),    64'd0);
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
